// File: rtl/apb_master_bridge_if.sv
// Bus bundle for the APB master bridge: processor request side plus APB slave side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  logic              p_start;
  logic              p_write;
  logic [SEL_W-1:0]  p_sel;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stable;
  logic              a_reset;
  logic [SEL_W-1:0]  a_sel;
  logic              a_enable;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_ready;

  modport master (
    input  p_start, p_write, p_sel, p_addr, p_wdata, a_rdata, a_ready,
    output p_rdata, p_stable, a_reset, a_sel, a_enable, a_write, a_addr, a_wdata
  );

  modport slave (
    output p_start, p_write, p_sel, p_addr, p_wdata, a_rdata, a_ready,
    input  p_rdata, p_stable, a_reset, a_sel, a_enable, a_write, a_addr, a_wdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns a one-cycle processor request into an APB
// SETUP/ACCESS transfer with PREADY wait states and reports completion on p_stable.
module apb_master_bridge #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  apb_master_bridge_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3
  } state_e;

  state_e            state_q,  state_d;
  logic [SEL_W-1:0]  sel_q,    sel_d;
  logic              enable_q, enable_d;
  logic              write_q,  write_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              stable_q, stable_d;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    enable_d = enable_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    stable_d = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d    = {SEL_W{1'b0}};
        enable_d = 1'b0;
        if (bus.p_start && (bus.p_sel != {SEL_W{1'b0}})) begin
          state_d = SETUP;
          sel_d   = bus.p_sel;
          write_d = bus.p_write;
          addr_d  = bus.p_addr;
          wdata_d = bus.p_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        enable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.a_ready) begin
          state_d  = DONE;
          sel_d    = {SEL_W{1'b0}};
          enable_d = 1'b0;
          stable_d = 1'b1;
          if (!write_q) begin
            rdata_d = bus.a_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      DONE: begin
        state_d  = IDLE;
        sel_d    = {SEL_W{1'b0}};
        enable_d = 1'b0;
      end
      default: begin
        // Unused encodings recover to a quiet bus.
        state_d  = IDLE;
        sel_d    = {SEL_W{1'b0}};
        enable_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_q    <= {SEL_W{1'b0}};
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      stable_q <= stable_d;
    end
  end

  assign bus.a_reset  = reset;
  assign bus.a_sel    = sel_q;
  assign bus.a_enable = enable_q;
  assign bus.a_write  = write_q;
  assign bus.a_addr   = addr_q;
  assign bus.a_wdata  = wdata_q;
  assign bus.p_rdata  = rdata_q;
  assign bus.p_stable = stable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, randomized
// transfers against a transaction-level model, and reset / ignored-start corner cases.
module tb_apb_master_bridge;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8), .SEL_W(2)) bus ();

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .SEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       write;
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] rdata;
    logic       poke;
    logic [7:0] exp_rdata;
  } vec_t;

  // Model state: what p_rdata must show and the last captured APB fields.
  logic [7:0] m_rdata;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] sel, input logic en,
                         input logic stb, input logic [7:0] rd);
    chk({tag, ".a_sel"},    32'(bus.a_sel),    32'(sel));
    chk({tag, ".a_enable"}, 32'(bus.a_enable), 32'(en));
    chk({tag, ".p_stable"}, 32'(bus.p_stable), 32'(stb));
    chk({tag, ".a_addr"},   32'(bus.a_addr),   32'(m_addr));
    chk({tag, ".a_write"},  32'(bus.a_write),  32'(m_write));
    chk({tag, ".a_wdata"},  32'(bus.a_wdata),  32'(m_wdata));
    chk({tag, ".p_rdata"},  32'(bus.p_rdata),  32'(rd));
  endtask

  // One full transfer, checked cycle by cycle at the falling edge.
  task automatic run_txn(input vec_t v);
    @(negedge clk);
    bus.p_start = 1'b1;
    bus.p_write = v.write;
    bus.p_sel   = v.sel;
    bus.p_addr  = v.addr;
    bus.p_wdata = v.wdata;
    @(negedge clk);
    bus.p_start = 1'b0;
    bus.p_addr  = 8'(~v.addr);
    bus.p_wdata = 8'(~v.wdata);
    m_addr  = v.addr;
    m_wdata = v.wdata;
    m_write = v.write;
    chk_bus("setup", v.sel, 1'b0, 1'b0, m_rdata);
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge clk);
      bus.p_start = 1'b0;
      chk_bus("access", v.sel, 1'b1, 1'b0, m_rdata);
      bus.a_ready = (i == v.waits) ? 1'b1 : 1'b0;
      bus.a_rdata = (i == v.waits) ? v.rdata : 8'($urandom);
      if (v.poke && i == 0) begin
        bus.p_start = 1'b1;
        bus.p_sel   = 2'd3;
        bus.p_write = ~v.write;
      end
    end
    if (!v.write) m_rdata = v.rdata;
    @(negedge clk);
    bus.p_start = 1'b0;
    bus.a_ready = 1'b0;
    chk_bus("done", 2'd0, 1'b0, 1'b1, m_rdata);
    @(negedge clk);
    chk_bus("idle", 2'd0, 1'b0, 1'b0, m_rdata);
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    total = 0;
    bad   = 0;
    m_rdata = 8'd0; m_addr = 8'd0; m_wdata = 8'd0; m_write = 1'b0;
    reset = 1'b0;
    bus.p_start = 1'b0; bus.p_write = 1'b0; bus.p_sel = 2'd0;
    bus.p_addr = 8'd0; bus.p_wdata = 8'd0; bus.a_rdata = 8'd0; bus.a_ready = 1'b0;

    vecs[0] = '{1'b1, 2'd1, 8'h10, 8'd5,  0, 8'hAA, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 2'd1, 8'd6,  8'h00, 0, 8'd5,  1'b0, 8'd5};
    vecs[2] = '{1'b1, 2'd1, 8'd5,  8'd4,  5, 8'hBB, 1'b0, 8'd5};
    vecs[3] = '{1'b0, 2'd1, 8'd5,  8'h00, 5, 8'd6,  1'b0, 8'd6};
    vecs[4] = '{1'b0, 2'd1, 8'd4,  8'h00, 1, 8'd7,  1'b0, 8'd7};
    vecs[5] = '{1'b1, 2'd2, 8'h33, 8'h44, 2, 8'hCC, 1'b1, 8'd7};

    repeat (2) @(negedge clk);
    chk_bus("reset", 2'd0, 1'b0, 1'b0, 8'd0);
    chk("reset.a_reset", 32'(bus.a_reset), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("run.a_reset", 32'(bus.a_reset), 32'd1);

    for (int k = 0; k < 6; k++) begin
      run_txn(vecs[k]);
      chk("vec.p_rdata", 32'(bus.p_rdata), 32'(vecs[k].exp_rdata));
    end

    // Start with no slave selected must leave the bus idle.
    @(negedge clk);
    bus.p_start = 1'b1; bus.p_sel = 2'd0; bus.p_addr = 8'h77; bus.p_write = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_bus("nosel", 2'd0, 1'b0, 1'b0, m_rdata);
    end
    bus.p_start = 1'b0;

    for (int n = 0; n < 20; n++) begin
      rv.write = 1'($urandom);
      rv.sel   = 2'($urandom_range(1, 3));
      rv.addr  = 8'($urandom);
      rv.wdata = 8'($urandom);
      rv.waits = $urandom_range(0, 4);
      rv.rdata = 8'($urandom);
      rv.poke  = 1'($urandom);
      rv.exp_rdata = rv.write ? m_rdata : rv.rdata;
      run_txn(rv);
      chk("rand.p_rdata", 32'(bus.p_rdata), 32'(rv.exp_rdata));
    end

    // Asynchronous reset in the middle of a waited ACCESS.
    @(negedge clk);
    bus.p_start = 1'b1; bus.p_write = 1'b0; bus.p_sel = 2'd1;
    bus.p_addr = 8'h5A; bus.p_wdata = 8'h3C; bus.a_ready = 1'b0;
    @(negedge clk);
    bus.p_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst.a_enable", 32'(bus.a_enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    m_rdata = 8'd0; m_addr = 8'd0; m_wdata = 8'd0; m_write = 1'b0;
    chk_bus("async_rst", 2'd0, 1'b0, 1'b0, 8'd0);
    chk("async_rst.a_reset", 32'(bus.a_reset), 32'd0);
    bus.a_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_bus("post_rst", 2'd0, 1'b0, 1'b0, 8'd0);
    end
    bus.a_ready = 1'b0;
    rv = '{1'b0, 2'd3, 8'h21, 8'h00, 1, 8'h9E, 1'b0, 8'h9E};
    run_txn(rv);
    chk("recover.p_rdata", 32'(bus.p_rdata), 32'h9E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
